// File: rtl/uart_echo_fifo.sv
// UART loopback engine: synchronised receiver -> circular FIFO -> transmitter.
// Good characters are echoed. Frames with framing or parity errors are reported and dropped.
module uart_echo_fifo #(
  parameter int CLK_DIV    = 434,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        uart_rx,
  output logic                        uart_tx,
  input  logic                        echo_en,
  output logic                        rx_err_frame,
  output logic                        rx_err_parity,
  output logic                        fifo_overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STOP_BITS * CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1   = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_M1    = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] STOP_M1   = CW'(STOP_BITS * CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2);

  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

  // Receiver registers
  logic [1:0]           sync_q, sync_d;
  logic                 rx_prev_q, rx_prev_d;
  rx_state_t            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic                 rx_stop_q, rx_stop_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 push_q, push_d;
  logic [DATA_BITS-1:0] push_data_q, push_data_d;
  logic                 err_frame_q, err_frame_d;
  logic                 err_par_q, err_par_d;
  logic                 rx_s, ferr_now;

  // FIFO registers
  logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 overflow_q, overflow_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rd_data_q;
  logic                 full, empty, pop, push_ok;

  // Transmitter registers
  tx_state_t            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;

  assign rx_s = sync_q[1];

  always_comb begin
    sync_d      = {sync_q[0], uart_rx};
    rx_prev_d   = rx_s;
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + 1'b1;
    rx_bit_d    = rx_bit_q;
    rx_stop_d   = rx_stop_q;
    rx_shift_d  = rx_shift_q;
    rx_ferr_d   = rx_ferr_q;
    rx_perr_d   = rx_perr_q;
    push_d      = 1'b0;
    push_data_d = rx_shift_q;
    err_frame_d = 1'b0;
    err_par_d   = 1'b0;
    ferr_now    = rx_ferr_q | ~rx_s;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_M1) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == LAST_BIT) begin
            rx_state_d = (PARITY != 0) ? RX_PAR : RX_STOP;
            rx_stop_d  = 1'b0;
            rx_ferr_d  = 1'b0;
            rx_perr_d  = 1'b0;
          end
        end
      end
      RX_PAR: begin
        if (rx_cnt_q == BIT_M1) begin
          rx_cnt_d   = '0;
          rx_perr_d  = (rx_s != par_bit(rx_shift_q));
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_M1) begin
          rx_cnt_d = '0;
          // A framing error masks a parity error in the same character.
          if (rx_stop_q == LAST_STOP) begin
            rx_state_d  = RX_IDLE;
            err_frame_d = ferr_now;
            err_par_d   = !ferr_now && rx_perr_q;
            push_d      = !ferr_now && !rx_perr_q && echo_en;
          end else begin
            rx_ferr_d = ferr_now;
            rx_stop_d = 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= 2'b11;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_stop_q   <= 1'b0;
      rx_shift_q  <= '0;
      rx_ferr_q   <= 1'b0;
      rx_perr_q   <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      err_frame_q <= 1'b0;
      err_par_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_stop_q   <= rx_stop_d;
      rx_shift_q  <= rx_shift_d;
      rx_ferr_q   <= rx_ferr_d;
      rx_perr_q   <= rx_perr_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      err_frame_q <= err_frame_d;
      err_par_q   <= err_par_d;
    end
  end

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push_q && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
    overflow_d = overflow_q | (push_q & ~push_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Read-before-write: a simultaneous push into the slot being popped returns the old entry.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data_q;
    if (pop)     rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          tx_state_d = TX_START;
          tx_d       = 1'b0;
        end
      end
      TX_START: begin
        // Popped data lands in rd_data_q one cycle after the pop, well inside the start bit.
        if (tx_cnt_q == BIT_M1) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_shift_d = rd_data_q;
          tx_par_d   = par_bit(rd_data_q);
          tx_d       = rd_data_q[0];
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_M1) begin
          tx_cnt_d   = '0;
          tx_bit_d   = tx_bit_q + 1'b1;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == LAST_BIT) begin
            tx_state_d = (PARITY != 0) ? TX_PAR : TX_STOP;
            tx_d       = (PARITY != 0) ? tx_par_q : 1'b1;
          end else begin
            tx_d = tx_shift_q[1];
          end
        end
      end
      TX_PAR: begin
        if (tx_cnt_q == BIT_M1) begin
          tx_cnt_d   = '0;
          tx_d       = 1'b1;
          tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == STOP_M1) begin
          tx_cnt_d = '0;
          if (!empty) begin
            pop        = 1'b1;
            tx_state_d = TX_START;
            tx_d       = 1'b0;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  assign uart_tx       = tx_q;
  assign rx_err_frame  = err_frame_q;
  assign rx_err_parity = err_par_q;
  assign fifo_overflow = overflow_q;
  assign fifo_level    = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed bench for uart_echo_fifo: drives serial frames, decodes uart_tx with a
// negedge monitor and checks echoes, error pulses, FIFO level and overflow.
module tb_uart_echo_fifo;
  localparam int CLK_DIV = 16;
  localparam int FRAME   = 11 * CLK_DIV;
  localparam int NB      = 140;

  logic       clk, rst, uart_rx, uart_tx, echo_en;
  logic       rx_err_frame, rx_err_parity, fifo_overflow;
  logic [2:0] fifo_level;

  uart_echo_fifo #(
    .CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx), .echo_en(echo_en),
    .rx_err_frame(rx_err_frame), .rx_err_parity(rx_err_parity),
    .fifo_overflow(fifo_overflow), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0, miss_cnt = 0;
  int cyc = 0, frame_pulses = 0, par_pulses = 0, level_max = 0, level_prev = 0, lvl_up_cyc = 0;
  logic tx_low_seen = 1'b0, mon_abort = 1'b0, mon_busy = 1'b0, mon_par = 1'b0;
  int mon_cnt = 0, mon_start = 0;
  logic [7:0] mon_data = 8'h00;
  logic [7:0] echo_q[$];
  int start_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle bookkeeping plus a bit-accurate decoder of the echoed stream.
  always @(negedge clk) begin
    cyc++;
    if (rx_err_frame === 1'b1) frame_pulses++;
    if (rx_err_parity === 1'b1) par_pulses++;
    if (int'(fifo_level) > level_max) level_max = int'(fifo_level);
    if (fifo_level != 0 && level_prev == 0) lvl_up_cyc = cyc;
    level_prev = int'(fifo_level);
    if (uart_tx === 1'b0) tx_low_seen = 1'b1;
    if (mon_abort) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (uart_tx === 1'b0) begin
        mon_busy  = 1'b1;
        mon_cnt   = 0;
        mon_start = cyc;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % CLK_DIV == CLK_DIV / 2) begin
        if (mon_cnt / CLK_DIV == 0) check("tx_start_bit", 32'(uart_tx), 32'd0);
        else if (mon_cnt / CLK_DIV <= 8) mon_data[mon_cnt / CLK_DIV - 1] = uart_tx;
        else if (mon_cnt / CLK_DIV == 9) mon_par = uart_tx;
        else begin
          check("tx_parity_bit", 32'(mon_par), 32'(^mon_data));
          check("tx_stop_bit", 32'(uart_tx), 32'd1);
          echo_q.push_back(mon_data);
          start_q.push_back(mon_start);
          $display("echo %02h start_cycle %0d", mon_data, mon_start);
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int stop_len);
    uart_rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    uart_rx = par;
    repeat (CLK_DIV) @(negedge clk);
    uart_rx = stop;
    repeat (stop_len) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic wait_echo(input int n, input string tag);
    int t;
    t = 0;
    while (echo_q.size() < n && t < 4 * FRAME) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check(tag, 32'(echo_q.size()), 32'(n));
  endtask

  initial begin
    int base, fp, pp, ok, t;
    logic [7:0] d;
    rst = 1'b1; uart_rx = 1'b1; echo_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_err_frame", 32'(rx_err_frame), 32'd0);
    check("rst_err_parity", 32'(rx_err_parity), 32'd0);
    check("rst_overflow", 32'(fifo_overflow), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single echo of 0xA5 (even parity bit 0)
    base = echo_q.size(); fp = frame_pulses; pp = par_pulses;
    send_frame(8'hA5, 1'b0, 1'b1, CLK_DIV);
    wait_echo(base + 1, "single_count");
    check("single_data", 32'(echo_q[base]), 32'hA5);
    check("single_latency", 32'(start_q[base] - lvl_up_cyc), 32'd1);
    check("single_no_frame_err", 32'(frame_pulses), 32'(fp));
    check("single_no_par_err", 32'(par_pulses), 32'(pp));

    // Burst: stop bits shortened to 10 cycles so RX gains 6 cycles/frame on TX and the FIFO fills
    base = echo_q.size(); fp = frame_pulses; pp = par_pulses; level_max = 0;
    for (int i = 0; i < NB; i++) begin
      d = 8'(i + 1);
      send_frame(d, ^d, 1'b1, 10);
    end
    repeat (8 * FRAME) @(negedge clk);
    check("burst_overflow", 32'(fifo_overflow), 32'd1);
    check("burst_level_max", 32'(level_max), 32'd4);
    check("burst_level_drained", 32'(fifo_level), 32'd0);
    check("burst_dropped_some", 32'(echo_q.size() - base < NB), 32'd1);
    for (int k = 0; k < 5; k++) check("burst_first5", 32'(echo_q[base + k]), 32'(k + 1));
    for (int k = 0; k < 4; k++) check("burst_no_gap", 32'(start_q[base + k + 1] - start_q[base + k]), 32'(FRAME));
    ok = 1;
    for (int k = base + 1; k < echo_q.size(); k++) if (echo_q[k] <= echo_q[k - 1]) ok = 0;
    check("burst_in_order", 32'(ok), 32'd1);
    check("burst_no_frame_err", 32'(frame_pulses), 32'(fp));
    check("burst_no_par_err", 32'(par_pulses), 32'(pp));

    // Errors: parity error, framing error, then a good character
    base = echo_q.size(); fp = frame_pulses; pp = par_pulses;
    send_frame(8'h3C, 1'b1, 1'b1, CLK_DIV);
    repeat (20) @(negedge clk);
    check("perr_pulse", 32'(par_pulses), 32'(pp + 1));
    check("perr_no_frame", 32'(frame_pulses), 32'(fp));
    send_frame(8'h3C, 1'b0, 1'b0, CLK_DIV);
    repeat (4) @(negedge clk);
    check("ferr_pulse", 32'(frame_pulses), 32'(fp + 1));
    check("ferr_no_parity", 32'(par_pulses), 32'(pp + 1));
    send_frame(8'h3C, 1'b0, 1'b1, CLK_DIV);
    wait_echo(base + 1, "err_echo_count");
    check("err_echo_data", 32'(echo_q[base]), 32'h3C);

    // Glitch rejection, then prove the receiver is idle with a good character
    base = echo_q.size(); fp = frame_pulses; pp = par_pulses;
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * FRAME) @(negedge clk);
    check("glitch_no_echo", 32'(echo_q.size()), 32'(base));
    check("glitch_no_errs", 32'(frame_pulses + par_pulses), 32'(fp + pp));
    check("glitch_level", 32'(fifo_level), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, CLK_DIV);
    wait_echo(base + 1, "glitch_echo_count");
    check("glitch_echo_data", 32'(echo_q[base]), 32'h5A);

    // Reset during the data bits of an echoed 0xFF
    base = echo_q.size();
    send_frame(8'hFF, 1'b0, 1'b1, CLK_DIV);
    t = 0;
    while (!mon_busy && t < 2 * FRAME) begin
      @(negedge clk);
      t++;
    end
    check("rst_tx_started", 32'(mon_busy), 32'd1);
    repeat (40) @(negedge clk);
    mon_abort = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_uart_tx", 32'(uart_tx), 32'd1);
    check("midrst_level", 32'(fifo_level), 32'd0);
    check("midrst_overflow", 32'(fifo_overflow), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    mon_abort = 1'b0;
    check("midrst_no_echo", 32'(echo_q.size()), 32'(base));
    send_frame(8'h55, 1'b0, 1'b1, CLK_DIV);
    wait_echo(base + 1, "midrst_echo_count");
    check("midrst_echo_data", 32'(echo_q[base]), 32'h55);

    // echo_en low: checked but not queued; parity errors still flagged
    echo_en = 1'b0;
    base = echo_q.size(); pp = par_pulses;
    @(negedge clk);
    level_max = 0; tx_low_seen = 1'b0;
    send_frame(8'h77, 1'b0, 1'b1, CLK_DIV);
    repeat (FRAME) @(negedge clk);
    check("noecho_level", 32'(level_max), 32'd0);
    check("noecho_tx_idle", 32'(tx_low_seen), 32'd0);
    check("noecho_count", 32'(echo_q.size()), 32'(base));
    send_frame(8'h77, 1'b1, 1'b1, CLK_DIV);
    repeat (10) @(negedge clk);
    check("noecho_perr_pulse", 32'(par_pulses), 32'(pp + 1));
    echo_en = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #(600_000);
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
